piso_bitstream_serializer: RTL and testbench
============================================

Name: piso_bitstream_serializer

Overview:
Upstream feeder for the team's serial Mealy pattern detectors (single-bit `in`, one bit per clock).
Accepts parallel words over a valid/ready handshake and emits them one bit per enabled cycle, with a bit_valid qualifier and an end-of-word pulse.
A one-entry holding register lets back-to-back words stream with no bubble between the last bit of one word and the first bit of the next.

Parameters:
DATA_W, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
s_valid  input  1  upstream word valid
s_ready  output  1  serializer can accept a word this cycle
s_data  input  DATA_W  parallel word
bit_en  input  1  bit-rate enable; low stalls shifting
bit_out  output  1  current serial bit
bit_valid  output  1  bit_out is valid and is consumed at this clock edge
word_done  output  1  single-cycle pulse coincident with the last bit of a word
busy  output  1  a word is in the shift register or the holding register

Behaviour:
- State: IDLE, SHIFT (2-state FSM). Registers:
  - sreg[DATA_W-1:0]
  - cnt[$clog2(DATA_W)-1:0]
  - hold[DATA_W-1:0] and hold_valid
- Reset (synchronous): state=IDLE, cnt=0, sreg=0, hold_valid=0.
  - During reset: s_ready=0, bit_valid=0, word_done=0.
  - Cycle after reset: s_ready=1, bit_out=0, busy=0.
- s_ready = !reset && !hold_valid. Handshake completes at an edge with s_valid && s_ready.
- bit_out = sreg[DATA_W-1] when MSB_FIRST, else sreg[0].
  - Shift toward the output end on every consumed bit; fill with 0.
- bit_valid = (state==SHIFT) && bit_en.
  - A bit is consumed at the edge where bit_valid=1. bit_en=0 holds sreg, cnt and state.
- word_done = bit_valid && cnt==DATA_W-1.
- busy = (state==SHIFT) || hold_valid.
- Load routing at an accepting edge:
  - IDLE: word loads directly into sreg; cnt=0; state=SHIFT.
    - Latency: the first bit appears with bit_valid the cycle after acceptance (given bit_en=1).
  - SHIFT, and word_done is not being consumed this cycle: word goes to hold; hold_valid=1.
  - SHIFT, and word_done is being consumed this cycle with hold empty: word loads directly into sreg; cnt=0; stay in SHIFT (no bubble).
- Last-bit edge (word_done=1):
  - hold_valid=1: sreg<=hold, hold_valid<=0, cnt<=0, stay in SHIFT.
  - Else if a handshake completes: direct load as above.
  - Else: state<=IDLE, cnt<=0.
- Not a conflict: hold full and last bit coincide. s_ready is already 0 that cycle, so only the hold-to-sreg move occurs.
- Invariant: IDLE implies hold_valid=0.
- Reset mid-word: all in-flight and held data is discarded. No word_done is produced for the discarded word.
- s_data is ignored when s_valid=0. Upstream must hold s_data/s_valid stable while s_ready=0.

Decomposition:
- Shared package `serial_pkg`:
  - state enum {IDLE, SHIFT}
  - CNT_W = $clog2(DATA_W) helper function
  - default DATA_W constant, shared with the detector testbenches
- Sub-module: `word_hold_reg` (one-entry holding register).
  - Ports: clk, reset, wr, din, rd, dout, full.
  - The serializer FSM, counter and shifter stay in the top module.

Test Plan (DATA_W=8 unless noted):
1. MSB_FIRST=1, bit_en=1; send 8'hB2 once.
   - bit_out = 1,0,1,1,0,0,1,0 on 8 consecutive bit_valid cycles, starting one cycle after acceptance.
   - word_done only on the 8th; then IDLE, busy=0.
2. Back-to-back 8'hB2, 8'h96, 8'h5A with s_valid held high.
   - 24 consecutive bit_valid cycles, no gap.
   - s_ready=0 while hold is full.
   - word_done on cycles 8, 16, 24.
   - Stream fed to the 10110/10010 detector gives y=1 at the expected bit positions.
3. MSB_FIRST=0; send 8'h0D.
   - bit_out = 1,0,1,1,0,0,0,0.
4. bit_en toggling 1,0,1,0 during 8'hB2.
   - Same 8-bit sequence, delivered over 16 cycles.
   - bit_valid low and bit_out, cnt frozen on bit_en=0 cycles.
   - word_done coincident with the 8th consumed bit.
5. Reset asserted after 3 bits of 8'hFF, with 8'h00 held in hold.
   - Next cycle: bit_valid=0, busy=0, s_ready=1; no word_done.
   - A fresh 8'hA5 then serializes as 1,0,1,0,0,1,0,1.
6. DATA_W=5, MSB_FIRST=1; send 5'b10110 then 5'b10010 back-to-back.
   - bit_out = 1,0,1,1,0,1,0,0,1,0 over 10 cycles.
   - word_done on cycles 5 and 10.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial feeder and the serial pattern detectors.
package serial_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-position counter width for a word of w bits (at least 1).
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry holding register: parks the next word while the shifter is busy.
module word_hold_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              full
);

  // wr only happens while empty and rd only while full, so they never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      full <= 1'b0;
    end else if (wr) begin
      dout <= din;
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_bitstream_serializer.sv
// Parallel-in/serial-out feeder: accepts words over valid/ready and emits one
// bit per enabled cycle, with a one-word holding register for bubble-free streaming.
module piso_bitstream_serializer
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              bit_en,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int unsigned      CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] sreg, sreg_n, sreg_shift;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              hold_wr, hold_rd, hold_full;
  logic [DATA_W-1:0] hold_dout;
  logic              accept;

  word_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk   (clk),
    .reset (reset),
    .wr    (hold_wr),
    .din   (s_data),
    .rd    (hold_rd),
    .dout  (hold_dout),
    .full  (hold_full)
  );

  assign s_ready    = !reset && !hold_full;
  assign accept     = s_valid && s_ready;
  assign bit_valid  = !reset && (state == SHIFT) && bit_en;
  assign word_done  = bit_valid && (cnt == LAST);
  assign busy       = (state == SHIFT) || hold_full;
  assign bit_out    = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];
  assign sreg_shift = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

  // State, shifter and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and load routing: sreg direct, via hold, or hold-to-sreg.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_n  = s_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (accept && !word_done) begin
          hold_wr = 1'b1;
        end
        if (word_done) begin
          cnt_n = '0;
          if (hold_full) begin
            sreg_n  = hold_dout;
            hold_rd = 1'b1;
          end else if (accept) begin
            sreg_n = s_data;
          end else begin
            sreg_n  = sreg_shift;
            state_n = IDLE;
          end
        end else if (bit_valid) begin
          sreg_n = sreg_shift;
          cnt_n  = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_bitstream_serializer.sv
// Self-checking bench: three serializer configurations against a bit-queue reference model.
module tb_piso_bitstream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] sv, ben;
  logic [7:0] sd [3];
  logic [2:0] rdy, bout, bv, wd, busy;

  piso_bitstream_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .reset(rst), .s_valid(sv[0]), .s_ready(rdy[0]), .s_data(sd[0]),
    .bit_en(ben[0]), .bit_out(bout[0]), .bit_valid(bv[0]), .word_done(wd[0]), .busy(busy[0]));
  piso_bitstream_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .clk(clk), .reset(rst), .s_valid(sv[1]), .s_ready(rdy[1]), .s_data(sd[1]),
    .bit_en(ben[1]), .bit_out(bout[1]), .bit_valid(bv[1]), .word_done(wd[1]), .busy(busy[1]));
  piso_bitstream_serializer #(.DATA_W(5), .MSB_FIRST(1'b1)) u_msb5 (
    .clk(clk), .reset(rst), .s_valid(sv[2]), .s_ready(rdy[2]), .s_data(sd[2][4:0]),
    .bit_en(ben[2]), .bit_out(bout[2]), .bit_valid(bv[2]), .word_done(wd[2]), .busy(busy[2]));

  int unsigned wid [3] = '{8, 8, 5};
  bit          msb [3] = '{1'b1, 1'b0, 1'b1};

  // Reference: per instance, the queue of bits still to be sent, each tagged {last_of_word, bit}.
  bit [1:0]   bq [3][$];
  logic [7:0] dq [3][$];
  bit         acc [3];

  int          n_checks, n_fail, cyc;
  int          ben_mode;
  bit          rnd_words, tog;
  logic [31:0] cap [3], wdm [3];
  int          ncap [3], first_c [3], last_c [3], acc_c [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_cap();
    for (int k = 0; k < 3; k++) begin
      cap[k] = '0; wdm[k] = '0; ncap[k] = 0;
      first_c[k] = -1; last_c[k] = -1; acc_c[k] = -1;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      if (!sv[k]) begin
        if (dq[k].size() > 0) begin
          sv[k] = 1'b1; sd[k] = dq[k].pop_front();
        end else if (rnd_words && $urandom_range(0, 2) != 0) begin
          sv[k] = 1'b1; sd[k] = 8'($urandom);
        end else begin
          sv[k] = 1'b0; sd[k] = 8'($urandom);
        end
      end
      case (ben_mode)
        0:       ben[k] = 1'b1;
        1:       ben[k] = tog;
        default: ben[k] = ($urandom_range(0, 3) != 0);
      endcase
    end
    tog = ~tog;
  endtask

  // Compare outputs mid-cycle, advance the model across the coming edge.
  task automatic step();
    #1;
    for (int k = 0; k < 3; k++) begin
      int   sz, words;
      logic e_rdy, e_bv, e_wd, e_bout, e_busy;
      sz     = bq[k].size();
      words  = (sz + int'(wid[k]) - 1) / int'(wid[k]);
      e_busy = (sz > 0);
      e_bout = (sz > 0) ? bq[k][0][0] : 1'b0;
      if (rst) begin
        e_rdy = 1'b0; e_bv = 1'b0; e_wd = 1'b0;
      end else begin
        e_rdy = (words < 2);
        e_bv  = (sz > 0) && ben[k];
        e_wd  = e_bv && bq[k][0][1];
      end
      check($sformatf("s_ready[%0d]", k),   32'(rdy[k]), 32'(e_rdy));
      check($sformatf("bit_valid[%0d]", k), 32'(bv[k]),  32'(e_bv));
      check($sformatf("word_done[%0d]", k), 32'(wd[k]),  32'(e_wd));
      if (!rst) begin
        check($sformatf("bit_out[%0d]", k), 32'(bout[k]), 32'(e_bout));
        check($sformatf("busy[%0d]", k),    32'(busy[k]), 32'(e_busy));
      end
      if (bv[k] === 1'b1) begin
        cap[k] = {cap[k][30:0], bout[k]};
        if (wd[k] === 1'b1) wdm[k][ncap[k]] = 1'b1;
        if (first_c[k] < 0) first_c[k] = cyc;
        last_c[k] = cyc;
        ncap[k]++;
      end
      acc[k] = 1'b0;
      if (rst) begin
        bq[k].delete();
      end else begin
        if (e_bv) void'(bq[k].pop_front());
        if (sv[k] && e_rdy) begin
          acc[k] = 1'b1;
          if (acc_c[k] < 0) acc_c[k] = cyc;
          for (int i = 0; i < int'(wid[k]); i++) begin
            int idx;
            idx = msb[k] ? int'(wid[k]) - 1 - i : i;
            bq[k].push_back({(i == int'(wid[k]) - 1), sd[k][idx]});
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) if (acc[k]) sv[k] = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while ((bq[0].size() + bq[1].size() + bq[2].size() +
            dq[0].size() + dq[1].size() + dq[2].size()) > 0 || sv != 3'b000) begin
      if (n >= max_cyc) begin
        check("drain_timeout", 32'(n), 32'(max_cyc + 1));
        break;
      end
      drive(); step(); n++;
    end
  endtask

  initial begin
    rst = 1'b1; sv = '0; ben = '0; tog = 1'b1;
    for (int k = 0; k < 3; k++) sd[k] = '0;
    ben_mode = 0; rnd_words = 1'b0; cyc = 0; n_checks = 0; n_fail = 0;
    clear_cap();
    @(negedge clk);
    drive(); step();
    drive(); step();
    rst = 1'b0;
    drive(); step();

    // Back-to-back streaming, LSB-first word, and a 5-bit pair.
    clear_cap();
    dq[0] = '{8'hB2, 8'h96, 8'h5A};
    dq[1] = '{8'h0D};
    dq[2] = '{8'h16, 8'h12};
    run_until_idle(100);
    check("stream_bits",     cap[0], 32'h00B2965A);
    check("stream_nbits",    32'(ncap[0]), 32'd24);
    check("stream_done_pos", wdm[0], 32'h00808080);
    check("stream_no_gap",   32'(last_c[0] - first_c[0]), 32'd23);
    check("first_latency",   32'(first_c[0] - acc_c[0]), 32'd1);
    check("lsb_first_bits",  cap[1], 32'h000000B0);
    check("w5_bits",         cap[2], 32'h000002D2);
    check("w5_done_pos",     wdm[2], 32'h00000210);

    // Toggling bit enable stretches one word over 16 cycles.
    clear_cap();
    ben_mode = 1; tog = 1'b1;
    dq[0] = '{8'hB2};
    run_until_idle(100);
    check("toggle_bits",     cap[0], 32'h000000B2);
    check("toggle_span",     32'(last_c[0] - first_c[0]), 32'd14);
    check("toggle_done_pos", wdm[0], 32'h00000080);

    // Reset mid-word with a word parked in the holding register.
    clear_cap();
    ben_mode = 0;
    for (int k = 0; k < 3; k++) dq[k] = '{8'hFF, 8'h00};
    for (int n = 0; n < 50 && ncap[0] < 3; n++) begin
      drive(); step();
    end
    check("pre_reset_bits", 32'(ncap[0]), 32'd3);
    rst = 1'b1;
    drive(); step();
    rst = 1'b0;
    drive(); step();
    check("reset_no_done", wdm[0], 32'h0);
    clear_cap();
    for (int k = 0; k < 3; k++) dq[k] = '{8'hA5};
    run_until_idle(100);
    check("post_reset_bits",  cap[0], 32'h000000A5);
    check("post_reset_nbits", 32'(ncap[0]), 32'd8);

    // Random traffic, random enable, occasional reset.
    ben_mode = 2; rnd_words = 1'b1;
    repeat (3000) begin
      rst = ($urandom_range(0, 149) == 0);
      drive(); step();
    end
    rst = 1'b0; rnd_words = 1'b0;
    run_until_idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
